// File: rtl/warp_mem_pkg.sv
// Shared memory-side types for the warp hart: instruction width and the
// instruction-fetch response record carried through delay lines and FIFOs.
package warp_mem_pkg;

   localparam int unsigned INSN_W          = 32;
   localparam int unsigned MAX_FETCH_WIDTH = 4;

   // Data is sized for the widest fetch; narrower configurations leave the top zero.
   typedef struct packed {
      logic [INSN_W*MAX_FETCH_WIDTH-1:0] data;
      logic                              fault;
   } imem_resp_t;

   typedef struct packed {
      logic       valid;
      imem_resp_t resp;
   } imem_slot_t;

endpackage

// File: rtl/warp_sync_fifo.sv
// Synchronous show-ahead FIFO with synchronous active-high reset.
// Push while full and pop while empty are ignored.
module warp_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/warp_imem_model.sv
// Instruction-memory responder for the warp_hart fetch port: preloadable array,
// fixed-latency in-order beats, stall injection and misalign/range faults.
module warp_imem_model
   import warp_mem_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH      = 39,
   parameter int unsigned            FETCH_WIDTH     = 2,
   parameter int unsigned            DEPTH           = 1024,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = 39'h4000000000,
   parameter int unsigned            LATENCY         = 2,
   parameter int unsigned            MAX_OUTSTANDING = 4
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_imem_ren,
   input  logic [ADDR_WIDTH-1:0]                 i_imem_raddr,
   output logic                                  o_imem_ready,
   output logic                                  o_imem_valid,
   output logic [INSN_W*FETCH_WIDTH-1:0]         o_imem_rdata,
   output logic                                  o_imem_fault,
   input  logic                                  i_hold,
   input  logic                                  i_load_en,
   input  logic [$clog2(DEPTH*FETCH_WIDTH)-1:0]  i_load_idx,
   input  logic [31:0]                           i_load_data
);

   localparam int unsigned DW      = INSN_W * FETCH_WIDTH;
   localparam int unsigned BEAT_SH = $clog2(4 * FETCH_WIDTH);
   localparam int unsigned BW      = $clog2(DEPTH);
   localparam int unsigned WORDS   = DEPTH * FETCH_WIDTH;
   localparam int unsigned LIW     = $clog2(WORDS);
   localparam int unsigned CW      = $clog2(MAX_OUTSTANDING + 1);

   logic [INSN_W-1:0]     mem [WORDS];
   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] beat;
   logic [BW-1:0]         beat_idx;
   logic                  fault_req;
   logic                  accept;
   logic                  present;
   logic [CW-1:0]         outstanding;
   imem_resp_t            rd_resp;
   imem_resp_t            head;
   imem_resp_t            fifo_dout;
   imem_slot_t            stage_in;
   imem_slot_t            arr;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;

   // Addresses below BASE_ADDR wrap to a huge offset and land in the range fault.
   assign off       = i_imem_raddr - BASE_ADDR;
   assign beat      = off >> BEAT_SH;
   assign beat_idx  = beat[BW-1:0];
   assign fault_req = (off[BEAT_SH-1:0] != '0) || (beat >= ADDR_WIDTH'(DEPTH));

   assign o_imem_ready = (outstanding < CW'(MAX_OUTSTANDING));
   assign accept       = i_imem_ren && o_imem_ready;

   always_comb begin
      rd_resp       = '0;
      rd_resp.fault = fault_req;
      if (!fault_req) begin
         for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            rd_resp.data[k*INSN_W +: INSN_W] =
               mem[LIW'(beat_idx) * LIW'(FETCH_WIDTH) + LIW'(k)];
         end
      end
   end

   // Write port has no reset so preloads survive and are honoured during reset.
   always_ff @(posedge i_clk) begin
      if (i_load_en) mem[i_load_idx] <= i_load_data;
   end

   always_comb begin
      stage_in       = '0;
      stage_in.valid = accept;
      stage_in.resp  = rd_resp;
   end

   generate
      if (LATENCY == 1) begin : g_no_dly
         assign arr = stage_in;
      end else begin : g_dly
         imem_slot_t pipe [LATENCY-1];
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int unsigned s = 0; s < LATENCY - 1; s++) pipe[s] <= '0;
            end else begin
               pipe[0] <= stage_in;
               for (int unsigned s = 1; s < LATENCY - 1; s++) pipe[s] <= pipe[s-1];
            end
         end
         assign arr = pipe[LATENCY-2];
      end
   endgenerate

   // An arriving beat bypasses the FIFO when it is empty and not held,
   // so the FIFO adds no cycle to the nominal latency.
   always_comb begin
      head      = fifo_empty ? arr.resp : fifo_dout;
      present   = !i_hold && (!fifo_empty || arr.valid);
      fifo_pop  = !i_hold && !fifo_empty;
      fifo_push = arr.valid && !(fifo_empty && !i_hold);
   end

   warp_sync_fifo #(
      .WIDTH ($bits(imem_resp_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (fifo_push),
      .din   (arr.resp),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         outstanding <= '0;
      end else if (accept && !present) begin
         outstanding <= outstanding + CW'(1);
      end else if (!accept && present) begin
         outstanding <= outstanding - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_imem_valid <= 1'b0;
         o_imem_fault <= 1'b0;
         o_imem_rdata <= '0;
      end else begin
         o_imem_valid <= present;
         o_imem_fault <= present && head.fault;
         o_imem_rdata <= present ? head.data[DW-1:0] : '0;
      end
   end

   generate
      if (FETCH_WIDTH < MAX_FETCH_WIDTH) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^{head.data[INSN_W*MAX_FETCH_WIDTH-1:DW], fifo_full};
      end else begin : g_unused_full
         logic unused_full;
         assign unused_full = fifo_full;
      end
   endgenerate

endmodule

// File: tb/tb_warp_imem_model.sv
// Directed bench for warp_imem_model in its default configuration.
module tb_warp_imem_model;

   localparam logic [38:0] BASE = 39'h4000000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ren;
   logic [38:0] raddr;
   logic        ready;
   logic        valid;
   logic [63:0] rdata;
   logic        fault;
   logic        hold;
   logic        load_en;
   logic [10:0] load_idx;
   logic [31:0] load_data;

   int n_checks = 0;
   int n_pass   = 0;
   int n_acc;

   logic [38:0] fa [3];

   warp_imem_model #(
      .ADDR_WIDTH      (39),
      .FETCH_WIDTH     (2),
      .DEPTH           (1024),
      .BASE_ADDR       (39'h4000000000),
      .LATENCY         (2),
      .MAX_OUTSTANDING (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_imem_ren   (ren),
      .i_imem_raddr (raddr),
      .o_imem_ready (ready),
      .o_imem_valid (valid),
      .o_imem_rdata (rdata),
      .o_imem_fault (fault),
      .i_hold       (hold),
      .i_load_en    (load_en),
      .i_load_idx   (load_idx),
      .i_load_data  (load_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wv(input int i);
      if (i == 0) return 32'h07800093;
      if (i == 1) return 32'h08206113;
      return 32'hC0DE0000 | 32'(i);
   endfunction

   function automatic logic [63:0] bt(input int b);
      return {wv(2*b + 1), wv(2*b)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; ren = 1'b0; raddr = '0; hold = 1'b0;
      load_en = 1'b0; load_idx = '0; load_data = '0;
      fa[0] = BASE + 39'd4;
      fa[1] = BASE + 39'h2000;
      fa[2] = 39'h0;

      // preload during reset
      for (int i = 0; i < 32; i++) begin
         load_en = 1'b1; load_idx = 11'(i); load_data = wv(i);
         tick();
      end
      load_en = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);

      // basic fetch
      ren = 1'b1; raddr = BASE;
      tick();
      ren = 1'b0;
      chk("basic_early", 64'(valid), 64'd0);
      tick();
      chk("basic_valid", 64'(valid), 64'd1);
      chk("basic_rdata", rdata, 64'h08206113_07800093);
      chk("basic_fault", 64'(fault), 64'd0);
      tick();
      chk("basic_pulse", 64'(valid), 64'd0);

      // streaming
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            ren = 1'b1; raddr = BASE + 39'(8*c);
            chk("stream_ready", 64'(ready), 64'd1);
         end else begin
            ren = 1'b0;
         end
         tick();
         chk("stream_valid", 64'(valid), 64'((c >= 1) && (c <= 8)));
         if (c >= 1 && c <= 8) chk("stream_rdata", rdata, bt(c - 1));
      end

      // faults
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            ren = 1'b1; raddr = fa[c];
         end else begin
            ren = 1'b0;
         end
         tick();
         chk("fault_valid", 64'(valid), 64'((c >= 1) && (c <= 3)));
         if (c >= 1 && c <= 3) begin
            chk("fault_flag", 64'(fault), 64'd1);
            chk("fault_rdata", rdata, 64'd0);
         end
      end

      // hold and backpressure
      hold = 1'b1; n_acc = 0;
      for (int k = 0; k < 8; k++) begin
         if (!ready) break;
         ren = 1'b1; raddr = BASE + 39'(8*(10 + n_acc));
         tick();
         ren = 1'b0;
         n_acc++;
         chk("hold_quiet", 64'(valid), 64'd0);
      end
      chk("hold_accepts", 64'(n_acc), 64'd4);
      chk("hold_ready_low", 64'(ready), 64'd0);
      tick();
      tick();
      chk("hold_still_low", 64'(ready), 64'd0);
      chk("hold_still_quiet", 64'(valid), 64'd0);
      hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("release_valid", 64'(valid), 64'd1);
         chk("release_rdata", rdata, bt(10 + k));
         if (k == 0) chk("release_ready", 64'(ready), 64'd1);
      end
      tick();
      chk("release_done", 64'(valid), 64'd0);

      // reset mid-flight
      hold = 1'b1;
      ren = 1'b1; raddr = BASE + 39'd16;
      tick();
      raddr = BASE + 39'd24;
      tick();
      ren = 1'b0;
      chk("mid_quiet", 64'(valid), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0; hold = 1'b0;
      chk("mid_ready", 64'(ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_dropped", 64'(valid), 64'd0);
      end
      ren = 1'b1; raddr = BASE + 39'd40;
      tick();
      ren = 1'b0;
      tick();
      chk("mid_refetch_valid", 64'(valid), 64'd1);
      chk("mid_refetch_rdata", rdata, bt(5));

      // read-first collision
      ren = 1'b1; raddr = BASE;
      load_en = 1'b1; load_idx = 11'd0; load_data = 32'hDEADBEEF;
      tick();
      ren = 1'b0; load_en = 1'b0;
      tick();
      chk("coll_valid", 64'(valid), 64'd1);
      chk("coll_old", rdata, {wv(1), wv(0)});
      ren = 1'b1; raddr = BASE;
      tick();
      ren = 1'b0;
      tick();
      chk("coll_new", rdata, {wv(1), 32'hDEADBEEF});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/warp_imem_model.md
# warp_imem_model

Parametrised instruction-memory responder for the `warp_hart` fetch port. It is used in hart benches and FPGA bring-up in place of a hand-driven `imem_valid`/`imem_rdata` sequence. It holds a preloadable word array and returns FETCH_WIDTH-instruction beats after a fixed configurable latency. It supports multiple outstanding requests, stall injection and fault reporting for misaligned or out-of-range fetches.

## Interface
- `ADDR_WIDTH`, 39, fetch address width.
- `FETCH_WIDTH`, 2, 32-bit instructions per beat; one of 1, 2, 4.
- `DEPTH`, 1024, number of beats in the array.
- `BASE_ADDR`, 39'h4000000000, byte address of beat 0.
- `LATENCY`, 2, cycles from accepted request to response; must be at least 1.
- `MAX_OUTSTANDING`, 4, in-flight plus queued responses; power of 2, at least LATENCY.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_imem_ren`  in  1  fetch request.
- `i_imem_raddr`  in  ADDR_WIDTH  byte address of the beat.
- `o_imem_ready`  out  1  request accepted this cycle if `i_imem_ren` is high.
- `o_imem_valid`  out  1  response beat valid; one-cycle pulse per response.
- `o_imem_rdata`  out  32*FETCH_WIDTH  instruction k in bits [32k+31:32k]; lower address in slot 0.
- `o_imem_fault`  out  1  qualifies `o_imem_valid`: the request was misaligned or out of range.
- `i_hold`  in  1  stall injection; no response is presented while high.
- `i_load_en`  in  1  preload write strobe.
- `i_load_idx`  in  $clog2(DEPTH*FETCH_WIDTH)  32-bit word index.
- `i_load_data`  in  32  word to write.

## Operation
- **Accept.** A request is accepted when `i_imem_ren && o_imem_ready`.
- **Ready.** `o_imem_ready = (outstanding < MAX_OUTSTANDING)`. `outstanding` counts requests that have been accepted and not yet presented.
- **Index.** `off = raddr - BASE_ADDR` (unsigned, ADDR_WIDTH bits). `beat = off >> log2(4*FETCH_WIDTH)`.
- **Fault.** A request faults if `off[log2(4*FETCH_WIDTH)-1:0] != 0` or `beat >= DEPTH`. An address below BASE_ADDR wraps to a large `off` and therefore faults.
  - A faulting request still produces exactly one response, in order.
  - That response has `o_imem_fault=1` and `o_imem_rdata=0`.
- **Read.** The array is read at accept. The beat plus fault flag enter a LATENCY-deep delay line, then a response FIFO of depth MAX_OUTSTANDING.
- **Present.** When the FIFO is non-empty and `i_hold` is low, the head is presented for one cycle (`o_imem_valid=1`) and popped. The hart has no ready signal, so every presented beat is consumed.
- **Ordering.** Responses are returned strictly in request order.
- **Outstanding counter.**
  - Increments on accept.
  - Decrements on present.
  - A simultaneous accept and present leaves it unchanged.
- **Preload.** `i_load_en` writes one word. A load and a fetch read of the same beat in the same cycle returns the old data (read-first). Loads are honoured during reset.
- **Reset.**
  - Clears the delay line, FIFO and counter.
  - Drives `o_imem_valid=0`, `o_imem_fault=0`, `o_imem_rdata=0`, `o_imem_ready=1`.
  - Any in-flight response is dropped and never presented.
  - The array contents are not cleared.

## Timing
- **Latency.** With the FIFO empty and `i_hold` low, a request accepted on edge N presents `o_imem_valid` high in the cycle after edge N+LATENCY−1, i.e. LATENCY cycles after the request cycle.
- **Throughput.** With MAX_OUTSTANDING ≥ LATENCY, back-to-back requests are accepted every cycle and return every cycle.
- **Hold.** While `i_hold` is high, responses accumulate in the FIFO. Once `outstanding` reaches MAX_OUTSTANDING, `o_imem_ready` drops in the same cycle. `i_hold` falling releases one beat per cycle.
- **Registered outputs.** All outputs are registered, except `o_imem_ready`, which is combinational from `outstanding` only and does not depend on `i_imem_ren`.
- **Overflow.** The FIFO cannot overflow, because capacity equals MAX_OUTSTANDING and is guarded by `o_imem_ready`.

## Structure
- **Shared package `warp_mem_pkg`:** instruction width constant `INSN_W=32` and the response struct `imem_resp_t` (data, fault).
- **Sub-module:** the FIFO is the synchronous `warp_sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty; synchronous active-high reset), reusable by the hart front end.
- **Local logic:** the delay line is a shift register of `{valid, imem_resp_t}`, kept local to this block.

## Test plan
- **Basic fetch.** Preload words 0,1 = 32'h07800093, 32'h08206113 (FETCH_WIDTH=2, LATENCY=2); request 39'h4000000000. Expect `o_imem_valid` 2 cycles later, `o_imem_rdata`=64'h08206113_07800093, fault=0.
- **Streaming.** Issue 8 back-to-back requests at BASE_ADDR + 8i. Expect 8 consecutive valid cycles with matching beats in order, and `o_imem_ready` held high throughout.
- **Faults.** Request BASE_ADDR+4 (misaligned), BASE_ADDR+8*DEPTH (out of range) and 39'h0. Expect three in-order responses with fault=1 and rdata=0.
- **Hold and backpressure.** Raise `i_hold` and issue requests until `o_imem_ready`=0, which must occur after exactly 4 accepts. Release `i_hold`. Expect 4 consecutive valid beats, with ready high again in the first release cycle.
- **Reset mid-flight.** Accept 2 requests, then assert `i_rst` for 1 cycle. Expect no `o_imem_valid` afterwards, ready=1, and the preloaded data still intact on the next fetch.
- **Read-first collision.** Load a new word to index 0 in the same cycle as a fetch of beat 0. Expect the old word in that response and the new word on a refetch.
